// File: rtl/cmd_resp_rx_if.sv
// cmd_resp_rx_if: CMD-line response receiver bus.
// master = command/register side (drives pad sample, enable and arm/config),
// slave  = cmd_resp_rx (drives status, payload and error flags).
interface cmd_resp_rx_if;
    logic         clk_en_i;
    logic         cmd_i;
    logic         start_rx_i;
    logic         long_resp_i;
    logic         check_crc_i;
    logic         check_index_i;
    logic [5:0]   expected_index_i;
    logic         busy_o;
    logic         done_o;
    logic [119:0] resp_o;
    logic         timeout_err_o;
    logic         crc_err_o;
    logic         end_bit_err_o;
    logic         index_err_o;

    modport master (
        output clk_en_i, cmd_i, start_rx_i, long_resp_i, check_crc_i,
               check_index_i, expected_index_i,
        input  busy_o, done_o, resp_o, timeout_err_o, crc_err_o,
               end_bit_err_o, index_err_o
    );

    modport slave (
        input  clk_en_i, cmd_i, start_rx_i, long_resp_i, check_crc_i,
               check_index_i, expected_index_i,
        output busy_o, done_o, resp_o, timeout_err_o, crc_err_o,
               end_bit_err_o, index_err_o
    );
endinterface

// File: rtl/cmd_resp_rx.sv
// cmd_resp_rx: SD CMD-line response receiver (48-bit R1/R3/R6/R7, 136-bit R2).
// Waits up to TimeoutCycles enables for a start bit, deserialises the frame
// MSB-first and reports payload plus timeout/CRC/end-bit/index errors.
// Optional feature: define SDHCI_CMD_RX_CRC_EN to build the CRC7 checker;
// otherwise crc_err_o is tied low and check_crc_i is ignored.
module cmd_resp_rx #(
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    cmd_resp_rx_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, FINISH} state_t;

    state_t       state_q, state_d;
    logic         accept, wait_tick, timeout_hit, start_seen, shift_en, last_bit;
    logic         cfg_long, cfg_check_index;
    logic [5:0]   cfg_index;
    logic [7:0]   wait_q, bit_q;
    logic [126:0] frame_q;
    logic [127:0] next_frame;
    logic         trans_q;
    logic [119:0] resp_q;
    logic         tmo_q, crc_q_err, end_q, idx_q;
    logic         crc_bad;

    // Only the low 128 frame bits are kept; bits 135:128 of an R2 carry no payload.
    assign next_frame = {frame_q, bus.cmd_i};

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode, datapath strobes and status outputs.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        wait_tick   = 1'b0;
        timeout_hit = 1'b0;
        start_seen  = 1'b0;
        shift_en    = 1'b0;
        last_bit    = 1'b0;
        bus.busy_o  = (state_q != IDLE);
        bus.done_o  = (state_q == FINISH);
        case (state_q)
            IDLE: begin
                if (bus.start_rx_i) begin
                    accept  = 1'b1;
                    state_d = WAIT_START;
                end
            end
            WAIT_START: begin
                if (bus.clk_en_i) begin
                    if (!bus.cmd_i) begin
                        start_seen = 1'b1;
                        state_d    = RECEIVE;
                    end else begin
                        wait_tick = 1'b1;
                        if (wait_q + 8'd1 == 8'(TimeoutCycles)) begin
                            timeout_hit = 1'b1;
                            state_d     = FINISH;
                        end
                    end
                end
            end
            RECEIVE: begin
                if (bus.clk_en_i) begin
                    shift_en = 1'b1;
                    if (bit_q == (cfg_long ? 8'd135 : 8'd47)) begin
                        last_bit = 1'b1;
                        state_d  = FINISH;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SDHCI_CMD_RX_CRC_EN
    logic [6:0] crc_q;
    logic       cfg_check_crc;
    logic       crc_feed, crc_fb;

    // bit_q is the 0-based position of the bit being sampled.
    assign crc_feed = cfg_long ? (bit_q >= 8'd8 && bit_q <= 8'd127) : (bit_q <= 8'd39);
    assign crc_fb   = bus.cmd_i ^ crc_q[6];
    assign crc_bad  = cfg_check_crc && (crc_q != next_frame[7:1]);

    // Serial CRC7 (x^7+x^3+1) over the payload bits as they arrive.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q         <= '0;
            cfg_check_crc <= 1'b0;
        end else if (accept) begin
            crc_q         <= '0;
            cfg_check_crc <= bus.check_crc_i;
        end else if (shift_en && crc_feed) begin
            crc_q <= {crc_q[5:3], crc_q[2] ^ crc_fb, crc_q[1:0], crc_fb};
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    // Config latch, counters, shift register and result/flag capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_long        <= 1'b0;
            cfg_check_index <= 1'b0;
            cfg_index       <= '0;
            wait_q          <= '0;
            bit_q           <= '0;
            frame_q         <= '0;
            trans_q         <= 1'b0;
            resp_q          <= '0;
            tmo_q           <= 1'b0;
            crc_q_err       <= 1'b0;
            end_q           <= 1'b0;
            idx_q           <= 1'b0;
        end else begin
            if (accept) begin
                cfg_long        <= bus.long_resp_i;
                cfg_check_index <= bus.check_index_i;
                cfg_index       <= bus.expected_index_i;
                wait_q          <= '0;
                bit_q           <= '0;
                frame_q         <= '0;
                trans_q         <= 1'b0;
                resp_q          <= '0;
                tmo_q           <= 1'b0;
                crc_q_err       <= 1'b0;
                end_q           <= 1'b0;
                idx_q           <= 1'b0;
            end
            if (wait_tick)   wait_q <= wait_q + 8'd1;
            if (timeout_hit) tmo_q  <= 1'b1;
            if (start_seen)  bit_q  <= 8'd1;
            if (shift_en) begin
                frame_q <= next_frame[126:0];
                bit_q   <= bit_q + 8'd1;
                // Transmission bit is the second bit on the wire for both lengths.
                if (bit_q == 8'd1) trans_q <= bus.cmd_i;
                // Results are captured with the last bit so they are valid with done_o.
                if (last_bit) begin
                    resp_q    <= cfg_long ? next_frame[127:8] : {88'b0, next_frame[39:8]};
                    end_q     <= trans_q | ~next_frame[0];
                    idx_q     <= cfg_check_index & ~cfg_long & (next_frame[45:40] != cfg_index);
                    crc_q_err <= crc_bad;
                end
            end
        end
    end

    assign bus.resp_o        = resp_q;
    assign bus.timeout_err_o = tmo_q;
    assign bus.crc_err_o     = crc_q_err;
    assign bus.end_bit_err_o = end_q;
    assign bus.index_err_o   = idx_q;

endmodule

// File: tb/tb_cmd_resp_rx.sv
// tb_cmd_resp_rx: directed bench for cmd_resp_rx with a frame-level reference
// model; a per-cycle compare process checks payload and flags against it.
module tb_cmd_resp_rx;

    typedef struct packed {
        logic [119:0] resp;
        logic         tmo;
        logic         crc;
        logic         endb;
        logic         idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   cmp_on = 1'b0;
    exp_t held = '0;
    exp_t exp_q[$];

    cmd_resp_rx_if bus();

    cmd_resp_rx #(.TimeoutCycles(64)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [123:0] act, input logic [123:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference CRC7: polynomial division of the n low bits of d, MSB first.
    function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
        logic [6:0] c = '0;
        logic       fb;
        for (int i = n - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [135:0] f48(input logic [5:0] idx, input logic [31:0] arg);
        logic [47:0] f;
        f      = {2'b00, idx, arg, 7'h00, 1'b1};
        f[7:1] = crc7({80'b0, f[47:8]}, 40);
        return {88'b0, f};
    endfunction

    function automatic logic [135:0] f136(input logic [119:0] payload);
        return {2'b00, 6'h3F, payload, crc7(payload, 120), 1'b1};
    endfunction

    function automatic exp_t model(input logic [135:0] f, input logic lng, input logic chk_crc,
                                   input logic chk_idx, input logic [5:0] eidx, input bit tmo);
        exp_t       r = '0;
        logic [6:0] c;
        logic       tx;
        if (tmo) begin
            r.tmo = 1'b1;
            return r;
        end
        if (lng) begin
            r.resp = f[127:8];
            c      = crc7(f[127:8], 120);
            tx     = f[134];
        end else begin
            r.resp = {88'b0, f[39:8]};
            c      = crc7({80'b0, f[47:8]}, 40);
            tx     = f[46];
        end
        r.endb = tx | ~f[0];
        r.idx  = chk_idx & ~lng & (f[45:40] != eidx);
`ifdef SDHCI_CMD_RX_CRC_EN
        r.crc  = chk_crc & (c != f[7:1]);
`else
        r.crc  = 1'b0;
        if (chk_crc && c != c) r.crc = 1'b0;
`endif
        return r;
    endfunction

    // Per-cycle compare: result on done_o, cleared while busy, held while idle.
    always @(negedge clk) begin
        exp_t e;
        if (cmp_on && !rst) begin
            if (bus.done_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done_o=1, expected 0");
                end else begin
                    e = exp_q.pop_front();
                    check("result", {bus.resp_o, bus.timeout_err_o, bus.crc_err_o,
                                     bus.end_bit_err_o, bus.index_err_o}, e);
                    held = e;
                end
            end else if (bus.busy_o) begin
                check("busy_cleared", {bus.resp_o, bus.timeout_err_o, bus.crc_err_o,
                                       bus.end_bit_err_o, bus.index_err_o}, '0);
            end else begin
                check("idle_held", {bus.resp_o, bus.timeout_err_o, bus.crc_err_o,
                                    bus.end_bit_err_o, bus.index_err_o}, held);
            end
        end
    end

    task automatic en_cycle(input logic b, input logic final_exp);
        @(negedge clk);
        bus.cmd_i    = b;
        bus.clk_en_i = 1'b1;
        @(negedge clk);
        bus.clk_en_i = 1'b0;
        bus.cmd_i    = 1'b1;
        check("done_timing", {123'b0, bus.done_o}, {123'b0, final_exp});
    endtask

    task automatic run(input logic [135:0] f, input logic lng, input logic chk_crc,
                       input logic chk_idx, input logic [5:0] eidx, input int idle,
                       input bit tmo, input int rst_at);
        int nbits = lng ? 136 : 48;
        if (rst_at < 0) exp_q.push_back(model(f, lng, chk_crc, chk_idx, eidx, tmo));
        @(negedge clk);
        bus.start_rx_i       = 1'b1;
        bus.long_resp_i      = lng;
        bus.check_crc_i      = chk_crc;
        bus.check_index_i    = chk_idx;
        bus.expected_index_i = eidx;
        @(negedge clk);
        bus.start_rx_i = 1'b0;
        check("busy_rise", {123'b0, bus.busy_o}, 124'd1);
        for (int i = 0; i < idle; i++) en_cycle(1'b1, tmo && (i == idle - 1));
        if (!tmo) begin
            for (int k = 0; k < nbits; k++) begin
                if (k == rst_at) begin
                    @(negedge clk);
                    rst  = 1'b1;
                    held = '0;
                    @(negedge clk);
                    rst  = 1'b0;
                    check("rst_busy", {123'b0, bus.busy_o}, '0);
                    check("rst_done", {123'b0, bus.done_o}, '0);
                end
                en_cycle(f[nbits - 1 - k], (rst_at < 0) && (k == nbits - 1));
            end
        end
        @(negedge clk);
        check("busy_fall", {123'b0, bus.busy_o}, '0);
        check("queue_drained", 124'(exp_q.size()), '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [135:0] fr;
        exp_t         m;
        bus.clk_en_i         = 1'b0;
        bus.cmd_i            = 1'b1;
        bus.start_rx_i       = 1'b0;
        bus.long_resp_i      = 1'b0;
        bus.check_crc_i      = 1'b0;
        bus.check_index_i    = 1'b0;
        bus.expected_index_i = '0;
        repeat (4) @(negedge clk);
        check("reset_busy", {123'b0, bus.busy_o}, '0);
        check("reset_done", {123'b0, bus.done_o}, '0);
        check("reset_outs", {bus.resp_o, bus.timeout_err_o, bus.crc_err_o,
                             bus.end_bit_err_o, bus.index_err_o}, '0);
        rst    = 1'b0;
        cmp_on = 1'b1;

        // Pin the reference model with well-known SD command CRCs and literal frames.
        check("crc_cmd0",  124'(crc7(120'h40_0000_0000, 40)), 124'h4A);
        check("crc_cmd17", 124'(crc7(120'h51_0000_0000, 40)), 124'h2A);
        check("crc_cmd8",  124'(crc7(120'h48_0000_01AA, 40)), 124'h43);
        check("frame_zero", 124'(f48(6'd0, 32'd0)), 124'h00_0000_0000_01);
        m = model(136'h00_0000_0001_01, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0);
        check("model_flip_resp", 124'(m.resp), 124'd1);
`ifdef SDHCI_CMD_RX_CRC_EN
        check("model_flip_crc", {123'b0, m.crc}, 124'd1);
`else
        check("model_flip_crc", {123'b0, m.crc}, 124'd0);
`endif

        run(136'h00_0000_0000_01, 1'b0, 1'b1, 1'b1, 6'd0, 5, 1'b0, -1);
        run(136'h00_0000_0001_01, 1'b0, 1'b1, 1'b1, 6'd0, 3, 1'b0, -1);
        run(136'h00_0000_0001_01, 1'b0, 1'b0, 1'b1, 6'd0, 1, 1'b0, -1);
        fr = f48(6'd8, 32'h0000_0900);
        run(fr, 1'b0, 1'b1, 1'b1, 6'd17, 2, 1'b0, -1);
        fr[0] = 1'b0;
        run(fr, 1'b0, 1'b1, 1'b1, 6'd17, 0, 1'b0, -1);
        fr = f48(6'd5, 32'h0F0F_1234);
        fr[46] = 1'b1;
        run(fr, 1'b0, 1'b1, 1'b1, 6'd5, 4, 1'b0, -1);
        run('0, 1'b0, 1'b1, 1'b1, 6'd0, 64, 1'b1, -1);
        run(f48(6'd3, 32'h1234_5678), 1'b0, 1'b1, 1'b1, 6'd3, 63, 1'b0, -1);
        run(f136({15{8'hA5}}), 1'b1, 1'b1, 1'b1, 6'd0, 2, 1'b0, -1);
        run(f48(6'd17, 32'hDEAD_BEEF), 1'b0, 1'b1, 1'b1, 6'd17, 3, 1'b0, 20);
        run(f48(6'd17, 32'hCAFE_0001), 1'b0, 1'b1, 1'b1, 6'd17, 3, 1'b0, -1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
